// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency 32-bit memory between instruction fetch and load/store.
// Round-robin arbitration, byte-lane stores, load extension, and misaligned split into two word accesses.
module mem_port_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int WA_W = ADDR_W - 2;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [2:0] {IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word1_q, word1_d;
  logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

  logic              grant_data;
  logic              split;
  logic [7:0]        lanes;
  logic [63:0]       rd_pair;
  logic [31:0]       resp_data;
  logic [WA_W-1:0]   word_a, word_b;
  logic              unused_addr_hi;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > 3'b010);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic needs_split(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && (off == 2'b11)) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rotate_lanes(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'd1:    return {w[23:0], w[31:24]};
      2'd2:    return {w[15:0], w[31:16]};
      2'd3:    return {w[7:0],  w[31:8]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [63:0] dw,
                                              input logic [1:0] off);
    logic [31:0] sh;
    sh = 32'(dw >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};
  assign split     = needs_split(f3_q, addr_q[1:0]);
  assign lanes     = {4'b0000, lane_mask(f3_q)} << addr_q[1:0];
  assign word_a    = addr_q[ADDR_W-1:2];
  assign word_b    = word_a + WA_W'(1);
  // First word comes from the register once a second word is on mem_rdata.
  assign rd_pair   = {mem_rdata, (state_q == WAIT2) ? word1_q : mem_rdata};
  assign resp_data = ((state_q == WAIT1) || (state_q == WAIT2)) ?
                     load_extend(f3_q, rd_pair, addr_q[1:0]) : 32'b0;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    word1_d     = word1_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_data  = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    mem_addr    = word_a;
    mem_wdata   = rotate_lanes(wdata_q, addr_q[1:0]);

    case (state_q)
      IDLE: begin
        if (reset_n && (if_req || d_req)) begin
          grant_data = d_req && (!if_req || (last_gnt_q == OWN_FETCH));
          d_gnt      = grant_data;
          if_gnt     = !grant_data;
          owner_d    = grant_data ? OWN_DATA : OWN_FETCH;
          addr_d     = grant_data ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
          we_d       = grant_data && d_we;
          f3_d       = grant_data ? d_funct3 : 3'b010;
          wdata_d    = d_wdata;
          state_d    = is_illegal(we_d, f3_d) ? RESP : ACC1;
        end
      end
      ACC1: begin
        mem_en  = 1'b1;
        mem_we  = we_q ? lanes[3:0] : 4'b0000;
        state_d = !we_q ? WAIT1 : (split ? ACC2 : RESP);
      end
      WAIT1: begin
        word1_d = mem_rdata;
        state_d = split ? ACC2 : RESP;
      end
      ACC2: begin
        mem_en   = 1'b1;
        mem_addr = word_b;
        mem_we   = we_q ? lanes[7:4] : 4'b0000;
        state_d  = we_q ? RESP : WAIT2;
      end
      WAIT2: state_d = RESP;
      RESP: begin
        last_gnt_d = owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == RESP) begin
      if (owner_d == OWN_DATA) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = resp_data;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = resp_data;
      end
    end

    if (!reset_n) begin
      mem_en = 1'b0;
      mem_we = 4'b0000;
    end
  end

  // Control and response registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= OWN_FETCH;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'b0;
      d_rdata_q   <= 32'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Latched request and captured first word
  always_ff @(posedge clock) begin
    owner_q <= owner_d;
    addr_q  <= addr_d;
    we_q    <= we_d;
    f3_q    <= f3_d;
    wdata_q <= wdata_d;
    word1_q <= word1_d;
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural memory, expected responses queued at grant
// and compared (data and latency) when rvalid pulses.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              if_req, if_gnt, if_rvalid;
  logic [31:0]       if_addr, if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]        d_funct3;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              busy;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  logic [31:0] d_exp_q[$];
  int          d_cyc_q[$];
  logic [31:0] i_exp_q[$];
  int          i_cyc_q[$];
  logic        glog[$];
  logic [31:0] mon_e;
  int          mon_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(negedge clock) begin
    if (d_gnt || if_gnt) begin
      chk("one_gnt", 32'(d_gnt & if_gnt), 32'd0);
      glog.push_back(d_gnt);
    end
    if (d_rvalid) begin
      if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = d_exp_q.pop_front();
        mon_c = d_cyc_q.pop_front();
        chk("d_rdata", d_rdata, mon_e);
        chk("d_latency", 32'(cyc), 32'(mon_c));
      end
    end
    if (if_rvalid) begin
      if (i_exp_q.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = i_exp_q.pop_front();
        mon_c = i_cyc_q.pop_front();
        chk("if_rdata", if_rdata, mon_e);
        chk("if_latency", 32'(cyc), 32'(mon_c));
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] v);
    @(posedge clock); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  task automatic d_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp, input int lat,
                      input bit push, output int gc);
    @(posedge clock); #1;
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    gc = -1;
    for (int i = 0; i < 60 && gc < 0; i++) begin
      @(negedge clock);
      if (d_gnt) gc = cyc;
    end
    if (gc < 0) chk("d_gnt_timeout", 32'd0, 32'd1);
    else if (push) begin
      d_exp_q.push_back(exp);
      d_cyc_q.push_back(gc + lat);
    end
    @(posedge clock); #1;
    d_req = 1'b0;
  endtask

  task automatic f_op(input logic [31:0] addr, input logic [31:0] exp, output int gc);
    @(posedge clock); #1;
    if_req = 1'b1; if_addr = addr;
    gc = -1;
    for (int i = 0; i < 60 && gc < 0; i++) begin
      @(negedge clock);
      if (if_gnt) gc = cyc;
    end
    if (gc < 0) chk("if_gnt_timeout", 32'd0, 32'd1);
    else begin
      i_exp_q.push_back(exp);
      i_cyc_q.push_back(gc + 3);
    end
    @(posedge clock); #1;
    if_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (d_exp_q.size() == 0 && i_exp_q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gd, gi, g, gd2, gi2;
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = '0;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    preload(10'h000, 32'h00500093);
    preload(10'h040, 32'h44332211);
    preload(10'h041, 32'h00008000);
    @(posedge clock); #1;
    reset_n = 1'b1;

    f_op(32'h0, 32'h00500093, gi);
    @(negedge clock);
    chk("fetch_mem_en", 32'(mem_en), 32'd1);
    chk("fetch_mem_addr", 32'(mem_addr), 32'd0);
    wait_idle();

    glog.delete();
    fork
      f_op(32'h0, 32'h00500093, gi);
      d_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h44332211, 3, 1'b1, gd);
    join
    wait_idle();
    chk("tie1_count", 32'(glog.size()), 32'd2);
    chk("tie1_first_data", 32'(glog[0]), 32'd1);
    chk("tie1_second_fetch", 32'(glog[1]), 32'd0);
    chk("tie1_fetch_gnt_cycle", 32'(gi), 32'(gd + 4));

    glog.delete();
    fork
      begin
        f_op(32'h0, 32'h00500093, gi);
        f_op(32'h0, 32'h00500093, gi2);
      end
      begin
        d_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h44332211, 3, 1'b1, gd);
        d_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h44332211, 3, 1'b1, gd2);
      end
    join
    wait_idle();
    chk("tie2_count", 32'(glog.size()), 32'd4);
    chk("tie2_order", 32'({glog[0], glog[1], glog[2], glog[3]}), 32'b1010);

    d_op(1'b0, 3'b000, 32'h105, 32'h0, 32'hFFFFFF80, 3, 1'b1, g);
    d_op(1'b0, 3'b100, 32'h105, 32'h0, 32'h00000080, 3, 1'b1, g);
    wait_idle();

    preload(10'h041, 32'h88776655);
    d_op(1'b0, 3'b101, 32'h106, 32'h0, 32'h00008877, 3, 1'b1, g);
    d_op(1'b0, 3'b001, 32'h106, 32'h0, 32'hFFFF8877, 3, 1'b1, g);
    wait_idle();

    d_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h66554433, 5, 1'b1, g);
    @(negedge clock);
    chk("splitlw_en1", 32'(mem_en), 32'd1);
    chk("splitlw_addr1", 32'(mem_addr), 32'h40);
    chk("splitlw_we1", 32'(mem_we), 32'd0);
    @(negedge clock);
    chk("splitlw_gap", 32'(mem_en), 32'd0);
    @(negedge clock);
    chk("splitlw_en2", 32'(mem_en), 32'd1);
    chk("splitlw_addr2", 32'(mem_addr), 32'h41);
    wait_idle();

    d_op(1'b1, 3'b001, 32'h0FFF, 32'h0000BEEF, 32'h0, 3, 1'b1, g);
    @(negedge clock);
    chk("splitsh_we1", 32'(mem_we), 32'b1000);
    chk("splitsh_addr1", 32'(mem_addr), 32'h3FF);
    chk("splitsh_byte1", 32'(mem_wdata[31:24]), 32'hEF);
    @(negedge clock);
    chk("splitsh_we2", 32'(mem_we), 32'b0001);
    chk("splitsh_addr2", 32'(mem_addr), 32'h000);
    chk("splitsh_byte2", 32'(mem_wdata[7:0]), 32'hBE);
    wait_idle();
    chk("splitsh_mem_hi", 32'(mem[10'h3FF][31:24]), 32'hEF);
    chk("splitsh_mem_lo", 32'(mem[10'h000][7:0]), 32'hBE);

    d_op(1'b1, 3'b010, 32'h200, 32'hCAFEBABE, 32'h0, 2, 1'b1, g);
    d_op(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFEBABE, 3, 1'b1, g);
    wait_idle();

    d_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 5, 1'b0, g);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_no_rvalid", 32'(d_rvalid), 32'd0);
      @(negedge clock);
    end
    d_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h44332211, 3, 1'b1, g);
    wait_idle();

    d_op(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b1, g);
    @(negedge clock);
    chk("illegal_ld_no_mem_en", 32'(mem_en), 32'd0);
    wait_idle();
    d_op(1'b1, 3'b100, 32'h100, 32'h12345678, 32'h0, 1, 1'b1, g);
    @(negedge clock);
    chk("illegal_st_no_mem_en", 32'(mem_en), 32'd0);
    wait_idle();
    chk("illegal_st_no_write", mem[10'h040], 32'h44332211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
